// File: rtl/lsu_axi_ctrl.sv
// LSU-to-AXI4 bridge: issues one single-beat AXI read or write per request, with
// alignment checking, byte-lane steering, load sign/zero extension and an optional bus timeout.
module lsu_axi_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int AXI_ID  = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  output logic [3:0]          arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic [3:0]          rid,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic [3:0]          bid,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_RESP} state_t;
  typedef enum logic [1:0] {ERR_OK, ERR_ALIGN, ERR_BUS, ERR_TIMEOUT} err_t;

  state_t              state_q, state_d;
  err_t                rsp_err_q, rsp_err_d;
  logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                stale_r_q, stale_r_d, stale_b_q, stale_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                misalign, busy, timeout_hit;

  // Shift the addressed lanes down, then extend from the top bit of the access size.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [1:0] sz, input logic uns);
    logic [DATA_W-1:0] s, mask;
    logic              sgn;
    s = d >> {off, 3'b000};
    case (sz)
      2'd0:    begin mask = DATA_W'(8'hFF);         sgn = s[7];  end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      sgn = s[15]; end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sgn = s[31]; end
      default: begin mask = '1;                     sgn = 1'b0;  end
    endcase
    return (s & mask) | ({DATA_W{sgn & ~uns}} & ~mask);
  endfunction

  always_comb begin
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  assign busy        = state_q inside {S_RADDR, S_RDATA, S_WREQ, S_WRESP};
  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cnt_d       = busy ? cnt_q + CNT_W'(1) : '0;
    stale_r_d   = stale_r_q && !(rvalid && rready_q);
    stale_b_d   = stale_b_q && !(bvalid && bready_q);
    // Outside the data phases, ready only stays up to swallow a beat orphaned by a timeout.
    rready_d    = stale_r_d;
    bready_d    = stale_b_d;

    case (state_q)
      S_IDLE: if (req_valid && req_ready_q) begin
        req_ready_d = 1'b0;
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        size_d      = req_size;
        uns_d       = req_unsigned;
        rsp_rdata_d = '0;
        rsp_err_d   = ERR_OK;
        if (misalign) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_ALIGN;
        end else if (req_we) begin
          state_d   = S_WREQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = S_RADDR;
          arvalid_d = 1'b1;
        end
      end
      S_RADDR: if (arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_RDATA;
      end
      S_RDATA: begin
        rready_d = !rvalid;
        if (rvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (rresp != 2'b00) ? ERR_BUS : ERR_OK;
          rsp_rdata_d = (rresp != 2'b00) ? '0 : load_ext(rdata, addr_q[OFF_W-1:0], size_q, uns_q);
        end
      end
      S_WREQ: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        bready_d = !bvalid;
        if (bvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (bresp != 2'b00) ? ERR_BUS : ERR_OK;
        end
      end
      S_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      arvalid_d   = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      rready_d    = 1'b0;
      bready_d    = 1'b0;
      stale_r_d   = stale_r_d || (state_q == S_RADDR) || (state_q == S_RDATA && !rvalid);
      stale_b_d   = stale_b_d || (state_q == S_WREQ) || (state_q == S_WRESP && !bvalid);
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = ERR_TIMEOUT;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      stale_r_q   <= 1'b0;
      stale_b_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      stale_r_q   <= stale_r_d;
      stale_b_q   <= stale_b_d;
      cnt_q       <= cnt_d;
    end
  end

  // NOTE: the request payload is not reset; it is only observed while a valid it qualifies is high.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
  end

  always_comb begin
    wdata = '0;
    wstrb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      wdata[8*i +: 8] = wdata_q[8*(i & ((1 << size_q) - 1)) +: 8];
      wstrb[i] = (i >= int'(addr_q[OFF_W-1:0])) && (i < int'(addr_q[OFF_W-1:0]) + (1 << size_q));
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign araddr    = addr_q;
  assign arvalid   = arvalid_q;
  assign arid      = 4'(AXI_ID);
  assign arlen     = 8'd0;
  assign arsize    = {1'b0, size_q};
  assign arburst   = 2'b01;
  assign rready    = rready_q;
  assign awaddr    = addr_q;
  assign awvalid   = awvalid_q;
  assign awid      = 4'(AXI_ID);
  assign awlen     = 8'd0;
  assign awsize    = {1'b0, size_q};
  assign awburst   = 2'b01;
  assign wlast     = 1'b1;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

  logic unused_axi;
  assign unused_axi = ^{rlast, rid, bid};

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Self-checking bench for lsu_axi_ctrl: directed corner cases plus randomized loads/stores
// against a byte-arithmetic reference model, with the bench acting as AXI slave.
module tb_lsu_axi_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk, rstn;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic              arvalid, arready, rvalid, rready, rlast;
  logic [3:0]        arid, rid, awid, bid;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic [DATA_W-1:0] rdata, wdata;
  logic [3:0]        wstrb;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  lsu_axi_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AXI_ID(1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rid(rid), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_hs   = 0;
  int ar_seen  = 0;
  int aw_seen  = 0;

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
    if (arvalid) ar_seen <= ar_seen + 1;
    if (awvalid || wvalid) aw_seen <= aw_seen + 1;
  end

  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic bit ref_misaligned(input logic [31:0] addr, input int sz);
    return (sz == 3) || ((addr % (1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input int sz, input bit uns);
    int     nb  = 1 << sz;
    int     off = int'(addr % 4);
    longint v;
    v = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * nb));
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int sz);
    case (sz)
      0:       return {24'd0, d[7:0]} * 32'h0101_0101;
      1:       return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [31:0] addr, input int sz);
    return 4'(((1 << (1 << sz)) - 1) << (addr % 4));
  endfunction

  // ---------------- drivers / slave ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input bit we, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    bit done = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) done = 1;
      tick();
    end
    req_valid = 0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL req_accept: req_ready never high within 20 cycles");
    end
  endtask

  task automatic serve_ar(input int dly);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) if (arvalid) seen = 1; else tick();
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL ar_wait: arvalid never rose");
      return;
    end
    cap_araddr = araddr; cap_arsize = arsize;
    repeat (dly) tick();
    n_checks++;
    if (araddr !== cap_araddr || arvalid !== 1'b1) begin
      n_errors++;
      $display("FAIL ar_stable: araddr %h arvalid %b, required %h 1", araddr, arvalid, cap_araddr);
    end
    arready = 1; tick(); arready = 0;
  endtask

  task automatic serve_r(input int dly, input logic [31:0] d, input logic [1:0] resp);
    bit done = 0;
    repeat (dly) tick();
    rvalid = 1; rdata = d; rresp = resp;
    for (int i = 0; i < 30 && !done; i++) begin
      if (rready) done = 1;
      tick();
    end
    rvalid = 0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL r_wait: rready never rose");
    end
  endtask

  task automatic serve_w(input int aw_dly, input int w_dly, input logic [1:0] resp, input int b_dly);
    bit done = 0;
    fork
      begin
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) if (awvalid) seen = 1; else tick();
        cap_awaddr = awaddr; cap_awsize = awsize;
        repeat (aw_dly) tick();
        n_checks++;
        if (!seen || awvalid !== 1'b1 || awaddr !== cap_awaddr) begin
          n_errors++;
          $display("FAIL aw_stable: awvalid %b awaddr %h, required 1 %h", awvalid, awaddr, cap_awaddr);
        end
        awready = 1; tick(); awready = 0;
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) if (wvalid) seen = 1; else tick();
        cap_wdata = wdata; cap_wstrb = wstrb;
        repeat (w_dly) tick();
        n_checks++;
        if (!seen || wvalid !== 1'b1 || wdata !== cap_wdata || wstrb !== cap_wstrb) begin
          n_errors++;
          $display("FAIL w_stable: wvalid %b wdata %h wstrb %b, required 1 %h %b",
                   wvalid, wdata, wstrb, cap_wdata, cap_wstrb);
        end
        wready = 1; tick(); wready = 0;
      end
    join
    repeat (b_dly) tick();
    bvalid = 1; bresp = resp;
    for (int i = 0; i < 30 && !done; i++) begin
      if (bready) done = 1;
      tick();
    end
    bvalid = 0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL b_wait: bready never rose");
    end
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic [1:0] e);
    bit done = 0;
    d = 'x; e = 'x;
    rsp_ready = 1;
    for (int i = 0; i < 30 && !done; i++) begin
      if (rsp_valid) begin d = rsp_rdata; e = rsp_err; done = 1; end
      tick();
    end
    rsp_ready = 0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL rsp_wait: rsp_valid never rose");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0;
    tick(); tick();
    n_checks++;
    if ({req_ready, rsp_valid, arvalid, awvalid, wvalid, rready, bready} !== 7'b100_0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: rdy/valids %b, required 1000000",
               {req_ready, rsp_valid, arvalid, awvalid, wvalid, rready, bready});
    end
    n_checks++;
    if (rsp_rdata !== 32'd0 || rsp_err !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_rsp: rdata %h err %0d, required 0 0", rsp_rdata, rsp_err);
    end
    rstn = 1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: req_ready %b, required 1", req_ready);
    end
  endtask

  task automatic test_load_sign();
    logic [31:0] d; logic [1:0] e;
    issue_req(0, 2'd0, 0, 32'h0000_1003, 32'd0);
    serve_ar(1);
    n_checks++;
    if (cap_araddr !== 32'h1003 || cap_arsize !== 3'd0 || arid !== 4'd1 || arlen !== 8'd0 || arburst !== 2'b01) begin
      n_errors++;
      $display("FAIL lb_ar: addr %h size %0d id %0d len %0d burst %0d, required 1003 0 1 0 1",
               cap_araddr, cap_arsize, arid, arlen, arburst);
    end
    serve_r(0, 32'h80FF_FF00, 2'd0);
    wait_rsp(d, e);
    n_checks++;
    if (d !== 32'hFFFF_FF80 || e !== 2'd0) begin
      n_errors++;
      $display("FAIL lb_signed: rdata %h err %0d, required ffffff80 0", d, e);
    end
    issue_req(0, 2'd0, 1, 32'h0000_1003, 32'd0);
    serve_ar(0);
    serve_r(0, 32'h80FF_FF00, 2'd0);
    wait_rsp(d, e);
    n_checks++;
    if (d !== 32'h0000_0080 || e !== 2'd0) begin
      n_errors++;
      $display("FAIL lbu_unsigned: rdata %h err %0d, required 00000080 0", d, e);
    end
  endtask

  task automatic test_store_sh();
    int          base;
    logic [1:0]  e;
    rsp_ready = 1;
    base = rsp_hs;
    issue_req(1, 2'd1, 0, 32'h0000_2002, 32'h0000_1234);
    serve_w(3, 0, 2'd0, 1);
    n_checks++;
    if (cap_wstrb !== 4'b1100 || cap_wdata[31:16] !== 16'h1234 || cap_awaddr !== 32'h2002 ||
        cap_awsize !== 3'd1 || wlast !== 1'b1) begin
      n_errors++;
      $display("FAIL sh_lanes: wstrb %b wdata %h awaddr %h awsize %0d wlast %b, required 1100 1234xxxx 2002 1 1",
               cap_wstrb, cap_wdata, cap_awaddr, cap_awsize, wlast);
    end
    e = rsp_err;
    n_checks++;
    if (rsp_hs != base || rsp_valid !== 1'b1 || e !== 2'd0) begin
      n_errors++;
      $display("FAIL sh_rsp_timing: early handshakes %0d valid %b err %0d, required 0 1 0",
               rsp_hs - base, rsp_valid, e);
    end
    repeat (8) tick();
    rsp_ready = 0;
    n_checks++;
    if (rsp_hs - base != 1) begin
      n_errors++;
      $display("FAIL sh_one_rsp: responses %0d, required 1", rsp_hs - base);
    end
  endtask

  task automatic test_misaligned();
    int          a0, w0, n;
    logic [31:0] d; logic [1:0] e;
    a0 = ar_seen; w0 = aw_seen;
    issue_req(0, 2'd2, 0, 32'h0000_3001, 32'd0);
    n = 0;
    while (!rsp_valid && n < 5) begin tick(); n++; end
    n_checks++;
    if (n > 1) begin
      n_errors++;
      $display("FAIL lw_misalign_latency: %0d extra cycles, required <= 1", n);
    end
    wait_rsp(d, e);
    n_checks++;
    if (e !== 2'd1 || d !== 32'd0 || ar_seen != a0 || aw_seen != w0) begin
      n_errors++;
      $display("FAIL lw_misalign: err %0d rdata %h ar_cycles %0d aw_cycles %0d, required 1 0 0 0",
               e, d, ar_seen - a0, aw_seen - w0);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] e;
    issue_req(0, 2'd2, 0, 32'h0000_4000, 32'd0);
    serve_ar(0);
    serve_r(1, $urandom, 2'd2);
    wait_rsp(d, e);
    n_checks++;
    if (e !== 2'd2 || d !== 32'd0) begin
      n_errors++;
      $display("FAIL lw_slverr: err %0d rdata %h, required 2 0", e, d);
    end
  endtask

  task automatic test_timeout();
    int          n, base;
    bit          got;
    logic [31:0] d; logic [1:0] e;
    issue_req(0, 2'd2, 0, 32'h0000_7000, 32'd0);
    n = 0;
    for (int i = 0; i < 40 && arvalid; i++) begin n++; tick(); end
    n_checks++;
    if (n != TIMEOUT || rsp_valid !== 1'b1 || rsp_err !== 2'd3 || arvalid !== 1'b0 || rready !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_ar: arvalid cycles %0d valid %b err %0d arvalid %b rready %b, required %0d 1 3 0 0",
               n, rsp_valid, rsp_err, arvalid, rready, TIMEOUT);
    end
    wait_rsp(d, e);
    rvalid = 1; rdata = $urandom; rresp = 2'd0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rready) got = 1;
      tick();
    end
    rvalid = 0;
    base = rsp_hs;
    rsp_ready = 1;
    repeat (5) tick();
    rsp_ready = 0;
    n_checks++;
    if (!got || rsp_hs != base || rready !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_late_r: consumed %0d extra_rsp %0d rready %b req_ready %b, required 1 0 0 1",
               got, rsp_hs - base, rready, req_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] word, d0, d; logic [1:0] e0, e;
    bit          stable = 1;
    word = $urandom;
    issue_req(0, 2'd1, 0, 32'h0000_5002, 32'd0);
    serve_ar(0);
    serve_r(1, word, 2'd0);
    rsp_ready = 0;
    for (int i = 0; i < 5 && !rsp_valid; i++) tick();
    d0 = rsp_rdata; e0 = rsp_err;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || rsp_err !== e0) stable = 0;
    end
    n_checks++;
    if (!stable || d0 !== ref_load(word, 32'h5002, 1, 0) || e0 !== 2'd0) begin
      n_errors++;
      $display("FAIL rsp_hold: stable %0d rdata %h err %0d, required 1 %h 0",
               stable, d0, e0, ref_load(word, 32'h5002, 1, 0));
    end
    wait_rsp(d, e);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rsp_release: rsp_valid %b req_ready %b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = rsp_hs;
    issue_req(0, 2'd2, 0, 32'h0000_6000, 32'd0);
    serve_ar(0);
    n_checks++;
    if (rready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_rdata: rready %b, required 1", rready);
    end
    rstn = 0;
    tick();
    rstn = 1;
    n_checks++;
    if ({req_ready, rsp_valid, arvalid, awvalid, wvalid, rready, bready} !== 7'b100_0000) begin
      n_errors++;
      $display("FAIL mid_reset: rdy/valids %b, required 1000000",
               {req_ready, rsp_valid, arvalid, awvalid, wvalid, rready, bready});
    end
    rsp_ready = 1;
    repeat (5) tick();
    rsp_ready = 0;
    n_checks++;
    if (rsp_hs != base) begin
      n_errors++;
      $display("FAIL mid_no_rsp: responses %0d, required 0", rsp_hs - base);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      bit          we, uns, mis;
      int          sz, a0, w0;
      logic [31:0] addr, wd, word, d, exp_d;
      logic [1:0]  resp, e, exp_e;
      we   = 1'($urandom);
      uns  = 1'($urandom);
      sz   = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << sz) - 1);
      wd   = $urandom;
      word = $urandom;
      resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      mis  = ref_misaligned(addr, sz);
      a0 = ar_seen; w0 = aw_seen;
      issue_req(we, 2'(sz), uns, addr, wd);
      if (mis) begin
        exp_e = 2'd1; exp_d = 32'd0;
      end else if (we) begin
        serve_w($urandom_range(0, 3), $urandom_range(0, 3), resp, $urandom_range(0, 3));
        exp_e = (resp != 0) ? 2'd2 : 2'd0; exp_d = 32'd0;
        n_checks++;
        if (cap_awaddr !== addr || cap_awsize !== 3'(sz) || cap_wstrb !== ref_wstrb(addr, sz) ||
            cap_wdata !== ref_wdata(wd, sz)) begin
          n_errors++;
          $display("FAIL rnd_store[%0d]: awaddr %h size %0d wstrb %b wdata %h, required %h %0d %b %h", t,
                   cap_awaddr, cap_awsize, cap_wstrb, cap_wdata, addr, sz, ref_wstrb(addr, sz), ref_wdata(wd, sz));
        end
      end else begin
        serve_ar($urandom_range(0, 3));
        serve_r($urandom_range(0, 3), word, resp);
        exp_e = (resp != 0) ? 2'd2 : 2'd0;
        exp_d = (resp != 0) ? 32'd0 : ref_load(word, addr, sz, uns);
        n_checks++;
        if (cap_araddr !== addr || cap_arsize !== 3'(sz)) begin
          n_errors++;
          $display("FAIL rnd_ar[%0d]: araddr %h size %0d, required %h %0d", t, cap_araddr, cap_arsize, addr, sz);
        end
      end
      wait_rsp(d, e);
      n_checks++;
      if (d !== exp_d || e !== exp_e || (mis && (ar_seen != a0 || aw_seen != w0))) begin
        n_errors++;
        $display("FAIL rnd_rsp[%0d]: we %0d size %0d addr %h rdata %h err %0d, required %h %0d",
                 t, we, sz, addr, d, e, exp_d, exp_e);
      end
    end
  endtask

  initial begin
    rstn = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; arready = 0; rdata = 0; rresp = 0; rlast = 1; rid = 4'd1; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bid = 4'd1; bvalid = 0;
    #1;
    test_reset();
    test_load_sign();
    test_store_sh();
    test_misaligned();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
